// File: rtl/motion_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : motion_sequencer_if
// Brief    : Command / status bundle between a CSR-side controller and the
//            motion_sequencer (valid/ready command channel, abort, motor
//            movement code and status flags).
// Revision : 1.0 - initial release
// ============================================================================
interface motion_sequencer_if #(
    parameter int unsigned DUR_W = 16
) ();
    logic             cmd_valid;
    logic [2:0]       cmd_mov;
    logic [DUR_W-1:0] cmd_ticks;
    logic             cmd_ready;
    logic             abort;
    logic [2:0]       movimiento;
    logic             busy;
    logic             done;

    // Command issuer side
    modport master (
        output cmd_valid, cmd_mov, cmd_ticks, abort,
        input  cmd_ready, movimiento, busy, done
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_mov, cmd_ticks, abort,
        output cmd_ready, movimiento, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/motion_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : motion_sequencer
// Brief    : Timed movement sequencer for the L298 driver. Holds each command
//            for ticks*PRESCALE cycles, chains identical movements seamlessly
//            and inserts a PAUSA dead-time whenever motion stops or changes.
// Revision : 1.0 - initial release
// ============================================================================
module motion_sequencer #(
    parameter int unsigned PRESCALE   = 100000,
    parameter int unsigned DEAD_TICKS = 10,
    parameter int unsigned DUR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    motion_sequencer_if.slave bus
);

    // A PRESCALE of 1 still needs a one-bit prescaler that never advances.
    localparam int unsigned      c_PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PRESCALE - 1);
    localparam logic [DUR_W-1:0] c_DEAD     = DUR_W'(DEAD_TICKS);
    localparam logic [DUR_W-1:0] c_ONE      = DUR_W'(1);
    localparam logic [2:0]       c_PAUSA    = 3'd0;
    localparam logic [2:0]       c_MOV_MAX  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_mov, w_mov_nxt;
    logic               r_done, w_done_nxt;
    logic               r_ready, w_ready_nxt;
    logic               r_pend_full, w_pend_full_nxt;
    logic [2:0]         r_pend_mov, w_pend_mov_nxt;
    logic [DUR_W-1:0]   r_pend_ticks, w_pend_ticks_nxt;
    logic [c_PRE_W-1:0] r_pre, w_pre_nxt;
    logic [DUR_W-1:0]   r_rem, w_rem_nxt;

    logic               w_accept;
    logic               w_last;

    // r_ready mirrors an empty buffer, so an accept can never coincide with a pop.
    assign w_accept = bus.cmd_valid & r_ready & ~bus.abort;
    // Final cycle of a timed interval (RUN or DEAD): last prescale count of last tick.
    assign w_last   = (r_pre == c_PRE_LAST) && (r_rem == c_ONE);

    // Next-state, buffer and counter logic; abort overrides everything at the end.
    always_comb begin
        w_state_nxt      = r_state;
        w_mov_nxt        = r_mov;
        w_done_nxt       = 1'b0;
        w_pend_full_nxt  = r_pend_full;
        w_pend_mov_nxt   = r_pend_mov;
        w_pend_ticks_nxt = r_pend_ticks;
        w_pre_nxt        = r_pre;
        w_rem_nxt        = r_rem;

        if (w_accept) begin
            w_pend_full_nxt  = 1'b1;
            w_pend_mov_nxt   = (bus.cmd_mov > c_MOV_MAX) ? c_PAUSA : bus.cmd_mov;
            w_pend_ticks_nxt = bus.cmd_ticks;
        end

        // Free-running interval timer while a movement or dead-time is active.
        if (r_state != ST_IDLE) begin
            if (r_pre == c_PRE_LAST) begin
                w_pre_nxt = '0;
                w_rem_nxt = r_rem - c_ONE;
            end else begin
                w_pre_nxt = r_pre + 1'b1;
            end
        end

        case (r_state)
            ST_IDLE: begin
                w_mov_nxt = c_PAUSA;
                if (r_pend_full) begin
                    w_pend_full_nxt = 1'b0;
                    if (r_pend_ticks == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_mov_nxt   = r_pend_mov;
                        w_pre_nxt   = '0;
                        w_rem_nxt   = r_pend_ticks;
                    end
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_done_nxt = 1'b1;
                    if (r_pend_full && (r_pend_mov == r_mov) && (r_pend_ticks != '0)) begin
                        // Same movement queued: continue without any gap.
                        w_pend_full_nxt = 1'b0;
                        w_pre_nxt       = '0;
                        w_rem_nxt       = r_pend_ticks;
                    end else if (DEAD_TICKS != 0) begin
                        w_state_nxt = ST_DEAD;
                        w_mov_nxt   = c_PAUSA;
                        w_pre_nxt   = '0;
                        w_rem_nxt   = c_DEAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_mov_nxt   = c_PAUSA;
                    end
                end
            end
            ST_DEAD: begin
                w_mov_nxt = c_PAUSA;
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_mov_nxt   = c_PAUSA;
            end
        endcase

        // Abort: drop queued and same-cycle commands, stop motion, no done.
        if (bus.abort) begin
            w_pend_full_nxt = 1'b0;
            w_done_nxt      = 1'b0;
            w_mov_nxt       = c_PAUSA;
            if ((r_state != ST_IDLE) && (DEAD_TICKS != 0)) begin
                w_state_nxt = ST_DEAD;
                w_pre_nxt   = '0;
                w_rem_nxt   = c_DEAD;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end

        w_ready_nxt = ~w_pend_full_nxt;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output, pending buffer and timer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mov        <= c_PAUSA;
            r_done       <= 1'b0;
            r_ready      <= 1'b1;
            r_pend_full  <= 1'b0;
            r_pend_mov   <= c_PAUSA;
            r_pend_ticks <= '0;
            r_pre        <= '0;
            r_rem        <= '0;
        end else begin
            r_mov        <= w_mov_nxt;
            r_done       <= w_done_nxt;
            r_ready      <= w_ready_nxt;
            r_pend_full  <= w_pend_full_nxt;
            r_pend_mov   <= w_pend_mov_nxt;
            r_pend_ticks <= w_pend_ticks_nxt;
            r_pre        <= w_pre_nxt;
            r_rem        <= w_rem_nxt;
        end
    end

    assign bus.cmd_ready  = r_ready;
    assign bus.movimiento = r_mov;
    assign bus.done       = r_done;
    assign bus.busy       = (r_state != ST_IDLE) | r_pend_full;

endmodule
`default_nettype wire

// File: tb/tb_motion_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_motion_sequencer
// Brief    : Self-checking bench for motion_sequencer (PRESCALE=4,
//            DEAD_TICKS=2): directed vector table, hand-written corner
//            sequences and random traffic against a cycle-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motion_sequencer;

    localparam int P  = 4;
    localparam int DT = 2;
    localparam int DW = 16;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    motion_sequencer_if #(.DUR_W(DW)) bus ();

    motion_sequencer #(
        .PRESCALE   (P),
        .DEAD_TICKS (DT),
        .DUR_W      (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its required value
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] m, input int t, input logic ab);
        bus.cmd_valid = v;
        bus.cmd_mov   = m;
        bus.cmd_ticks = DW'(t);
        bus.abort     = ab;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       v;
        logic [2:0] mov;
        int         ticks;
        int         n;
        logic [2:0] e_mov;
        logic       e_done;
        logic       e_ready;
        logic       e_busy;
    } vec_t;
    vec_t vecs[$];

    function automatic void addv(input logic v, input logic [2:0] mov, input int t, input int n,
                                 input logic [2:0] em, input logic ed, input logic er, input logic eb);
        vec_t r;
        r.v = v; r.mov = mov; r.ticks = t; r.n = n;
        r.e_mov = em; r.e_done = ed; r.e_ready = er; r.e_busy = eb;
        vecs.push_back(r);
    endfunction

    // ---------------- behavioural reference model ----------------
    // Tracks remaining cycles of the current interval directly (ticks*P).
    typedef struct {
        logic [2:0] code;
        int         ticks;
    } cmd_t;
    cmd_t       m_q[$];
    int         m_mode;   // 0 idle, 1 moving, 2 dead-time
    int         m_left;
    logic [2:0] m_mov;
    logic       m_done;

    task automatic model_reset();
        m_q.delete();
        m_mode = 0; m_left = 0; m_mov = 3'd0; m_done = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [2:0] mv, input int t, input logic ab);
        cmd_t c;
        logic acc;
        logic nd;
        acc = v && (m_q.size() == 0) && !ab;
        nd  = 1'b0;
        if (ab) begin
            m_q.delete();
            m_mov = 3'd0;
            if (m_mode != 0) begin m_mode = 2; m_left = DT * P; end
        end else begin
            if (m_mode == 0) begin
                if (m_q.size() != 0) begin
                    c = m_q.pop_front();
                    if (c.ticks == 0) nd = 1'b1;
                    else begin m_mode = 1; m_left = c.ticks * P; m_mov = c.code; end
                end
            end else if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) begin
                    nd = 1'b1;
                    if (m_q.size() != 0 && m_q[0].code == m_mov && m_q[0].ticks > 0) begin
                        c = m_q.pop_front();
                        m_left = c.ticks * P;
                    end else begin
                        m_mode = 2; m_left = DT * P; m_mov = 3'd0;
                    end
                end
            end else begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
            if (acc) begin
                c.code  = (mv > 3'd4) ? 3'd0 : mv;
                c.ticks = t;
                m_q.push_back(c);
            end
        end
        m_done = nd;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt;
        logic       rv;
        logic [2:0] rm;
        int         rt;
        logic       ra;

        n_checks = 0;
        n_fail   = 0;
        drive(1'b0, 3'd0, 0, 1'b0);
        reset = 1'b1;

        // Basic timing {AVANCE,3}
        addv(1, 2, 3, 1,  0, 0, 1, 0);
        addv(0, 0, 0, 1,  0, 0, 0, 1);
        addv(0, 0, 0, 12, 2, 0, 1, 1);
        addv(0, 0, 0, 1,  0, 1, 1, 1);
        addv(0, 0, 0, 7,  0, 0, 1, 1);
        addv(0, 0, 0, 2,  0, 0, 1, 0);
        // Seamless chaining {AVANCE,2} + {AVANCE,1}
        addv(1, 2, 2, 1,  0, 0, 1, 0);
        addv(0, 0, 0, 1,  0, 0, 0, 1);
        addv(1, 2, 1, 1,  2, 0, 1, 1);
        addv(0, 0, 0, 7,  2, 0, 0, 1);
        addv(0, 0, 0, 1,  2, 1, 1, 1);
        addv(0, 0, 0, 3,  2, 0, 1, 1);
        addv(0, 0, 0, 1,  0, 1, 1, 1);
        addv(0, 0, 0, 7,  0, 0, 1, 1);
        addv(0, 0, 0, 2,  0, 0, 1, 0);
        // Reversal {AVANCE,2} + {RETROCESO,2}
        addv(1, 2, 2, 1,  0, 0, 1, 0);
        addv(0, 0, 0, 1,  0, 0, 0, 1);
        addv(1, 1, 2, 1,  2, 0, 1, 1);
        addv(0, 0, 0, 7,  2, 0, 0, 1);
        addv(0, 0, 0, 1,  0, 1, 0, 1);
        addv(0, 0, 0, 7,  0, 0, 0, 1);
        addv(0, 0, 0, 1,  0, 0, 0, 1);
        addv(0, 0, 0, 8,  1, 0, 1, 1);
        addv(0, 0, 0, 1,  0, 1, 1, 1);
        addv(0, 0, 0, 7,  0, 0, 1, 1);
        addv(0, 0, 0, 2,  0, 0, 1, 0);
        // Zero-tick command, then out-of-range code 7 for one tick
        addv(1, 2, 0, 1,  0, 0, 1, 0);
        addv(0, 0, 0, 1,  0, 0, 0, 1);
        addv(0, 0, 0, 1,  0, 1, 1, 0);
        addv(0, 0, 0, 2,  0, 0, 1, 0);
        addv(1, 7, 1, 1,  0, 0, 1, 0);
        addv(0, 0, 0, 1,  0, 0, 0, 1);
        addv(0, 0, 0, 4,  0, 0, 1, 1);
        addv(0, 0, 0, 1,  0, 1, 1, 1);
        addv(0, 0, 0, 7,  0, 0, 1, 1);
        addv(0, 0, 0, 2,  0, 0, 1, 0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset movimiento", 32'(bus.movimiento), 0);
        chk("reset cmd_ready",  32'(bus.cmd_ready),  1);
        chk("reset busy",       32'(bus.busy),       0);
        chk("reset done",       32'(bus.done),       0);
        reset = 1'b0;

        // Directed table
        foreach (vecs[k]) begin
            for (int j = 0; j < vecs[k].n; j++) begin
                @(negedge clk);
                chk($sformatf("vec%0d.%0d movimiento", k, j), 32'(bus.movimiento), 32'(vecs[k].e_mov));
                chk($sformatf("vec%0d.%0d done", k, j),       32'(bus.done),       32'(vecs[k].e_done));
                chk($sformatf("vec%0d.%0d cmd_ready", k, j),  32'(bus.cmd_ready),  32'(vecs[k].e_ready));
                chk($sformatf("vec%0d.%0d busy", k, j),       32'(bus.busy),       32'(vecs[k].e_busy));
                drive(vecs[k].v, vecs[k].mov, vecs[k].ticks, 1'b0);
            end
        end

        // Abort mid-RUN: {GIROD,10} running with {GIROI,5} queued, abort in RUN cycle 6
        @(negedge clk); drive(1'b1, 3'd3, 10, 1'b0);
        @(negedge clk); drive(1'b0, 3'd0, 0, 1'b0);
        @(negedge clk);
        chk("abort run start mov", 32'(bus.movimiento), 3);
        chk("abort run start ready", 32'(bus.cmd_ready), 1);
        drive(1'b1, 3'd4, 5, 1'b0);
        @(negedge clk); drive(1'b0, 3'd0, 0, 1'b0);
        chk("abort queued ready", 32'(bus.cmd_ready), 0);
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("abort cycle6 mov", 32'(bus.movimiento), 3);
        drive(1'b0, 3'd0, 0, 1'b1);
        @(negedge clk); drive(1'b0, 3'd0, 0, 1'b0);
        chk("abort next mov",   32'(bus.movimiento), 0);
        chk("abort next ready", 32'(bus.cmd_ready),  1);
        chk("abort next done",  32'(bus.done),       0);
        chk("abort next busy",  32'(bus.busy),       1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("abort dead%0d busy", i), 32'(bus.busy), 1);
            chk($sformatf("abort dead%0d done", i), 32'(bus.done), 0);
            chk($sformatf("abort dead%0d mov", i),  32'(bus.movimiento), 0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("abort idle%0d busy", i), 32'(bus.busy), 0);
            chk($sformatf("abort idle%0d mov", i),  32'(bus.movimiento), 0);
            chk($sformatf("abort idle%0d done", i), 32'(bus.done), 0);
        end

        // Backpressure: cmd_valid held during RUN
        @(negedge clk); drive(1'b1, 3'd2, 3, 1'b0);
        @(negedge clk); drive(1'b0, 3'd0, 0, 1'b0);
        @(negedge clk);
        chk("bp run mov", 32'(bus.movimiento), 2);
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) @(negedge clk);
            if (bus.cmd_ready) acc_cnt++;
            drive(1'b1, 3'd3, 1, 1'b0);
        end
        @(negedge clk); drive(1'b0, 3'd0, 0, 1'b0);
        chk("bp accept count", 32'(acc_cnt), 1);
        chk("bp ready held low", 32'(bus.cmd_ready), 0);
        chk("bp still running", 32'(bus.movimiento), 2);

        // Asynchronous reset mid-RUN, observed before the next clock edge
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("async reset mov",   32'(bus.movimiento), 0);
        chk("async reset ready", 32'(bus.cmd_ready),  1);
        chk("async reset busy",  32'(bus.busy),       0);
        chk("async reset done",  32'(bus.done),       0);
        @(negedge clk); reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post reset busy", 32'(bus.busy), 0);
        chk("post reset mov",  32'(bus.movimiento), 0);

        // Random traffic against the reference model
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            chk("rnd movimiento", 32'(bus.movimiento), 32'(m_mov));
            chk("rnd done",       32'(bus.done),       32'(m_done));
            chk("rnd cmd_ready",  32'(bus.cmd_ready),  32'(m_q.size() == 0));
            chk("rnd busy",       32'(bus.busy),       32'((m_mode != 0) || (m_q.size() != 0)));
            rv = ($urandom_range(0, 9) < 4);
            rm = 3'($urandom_range(0, 7));
            rt = int'($urandom_range(0, 3));
            ra = ($urandom_range(0, 59) == 0);
            drive(rv, rm, rt, ra);
            @(posedge clk);
            model_step(rv, rm, rt, ra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
